// File: rtl/rv_exec_unit.sv
// rv_exec_unit: multi-cycle RV32I/RV32M integer execute unit holding one operation in flight.
// ALU and illegal ops finish in one cycle, multiplies in MUL_LAT cycles, divides in XLEN+1 cycles.
module rv_exec_unit #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             illegal
);
  localparam int SHW   = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_SLL   = 5'd2,  OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4,  OP_XOR    = 5'd5,  OP_SRL   = 5'd6,  OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8,  OP_AND    = 5'd9,  OP_MUL   = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV  = 5'd14, OP_DIVU = 5'd15;
  localparam logic [4:0] OP_REM  = 5'd16, OP_REMU   = 5'd17;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic [XLEN-1:0]    a_q, a_d;      // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0]    b_q, b_d;      // multiplier, or divisor magnitude
  logic [XLEN-1:0]    rem_q, rem_d;
  logic               qneg_q, qneg_d, rneg_q, rneg_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               illegal_q, illegal_d;

  logic               accept;
  logic               in_div_signed;
  logic [XLEN:0]      div_shift;
  logic               div_bit;
  logic [XLEN-1:0]    div_rem_nx, div_quo_nx;

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] alu_res(input logic [4:0] f_op, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    case (f_op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLL:  r = x << y[SHW-1:0];
      OP_SLT:  r = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, x < y};
      OP_XOR:  r = x ^ y;
      OP_SRL:  r = x >> y[SHW-1:0];
      OP_SRA:  r = $signed(x) >>> y[SHW-1:0];
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      default: r = ZERO;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mul_res(input logic [4:0] f_op, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
    logic [2*XLEN-1:0] xe, ye, p;
    if (f_op == OP_MULH || f_op == OP_MULHSU) begin
      xe = {{XLEN{x[XLEN-1]}}, x};
    end else begin
      xe = {ZERO, x};
    end
    if (f_op == OP_MULH) begin
      ye = {{XLEN{y[XLEN-1]}}, y};
    end else begin
      ye = {ZERO, y};
    end
    p = xe * ye;
    return (f_op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign in_ready      = ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready)) & ~flush & ~rst;
  assign accept        = in_valid & in_ready;
  assign in_div_signed = (op == OP_DIV) | (op == OP_REM);
  assign out_valid     = (state_q == S_DONE);
  assign result        = result_q;
  assign tag_out       = tag_q;
  assign illegal       = illegal_q;

  // One restoring-division step on the magnitudes held in a_q/b_q/rem_q.
  assign div_shift  = {rem_q, a_q[XLEN-1]};
  assign div_bit    = (div_shift >= {1'b0, b_q});
  assign div_rem_nx = div_bit ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
  assign div_quo_nx = {a_q[XLEN-2:0], div_bit};

  // Next-state and datapath: flush, then accept, then in-flight progress.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    tag_d     = tag_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      op_d      = op;
      tag_d     = tag_in;
      cnt_d     = '0;
      illegal_d = 1'b0;
      if (op > OP_REMU) begin
        state_d   = S_DONE;
        result_d  = ZERO;
        illegal_d = 1'b1;
      end else if (op <= OP_AND) begin
        state_d  = S_DONE;
        result_d = alu_res(op, a, b);
      end else if (op <= OP_MULHU) begin
        if (MUL_LAT == 1) begin
          state_d  = S_DONE;
          result_d = mul_res(op, a, b);
        end else begin
          state_d = S_MUL;
          a_d     = a;
          b_d     = b;
        end
      end else if (b == ZERO) begin
        state_d  = S_DONE;
        result_d = (op == OP_DIV || op == OP_DIVU) ? ONES : a;
      end else if (in_div_signed && a == MIN_NEG && b == ONES) begin
        state_d  = S_DONE;
        result_d = (op == OP_DIV) ? a : ZERO;
      end else begin
        state_d = S_DIV;
        a_d     = (in_div_signed && a[XLEN-1]) ? neg(a) : a;
        b_d     = (in_div_signed && b[XLEN-1]) ? neg(b) : b;
        rem_d   = ZERO;
        qneg_d  = in_div_signed & (a[XLEN-1] ^ b[XLEN-1]);
        rneg_d  = in_div_signed & a[XLEN-1];
      end
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_q == MUL_LAST) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = mul_res(op_q, a_q, b_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DIV: begin
          a_d   = div_quo_nx;
          rem_d = div_rem_nx;
          if (cnt_q == DIV_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            if (op_q == OP_DIV || op_q == OP_DIVU) begin
              result_d = qneg_q ? neg(div_quo_nx) : div_quo_nx;
            end else begin
              result_d = rneg_q ? neg(div_rem_nx) : div_rem_nx;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= 5'd0;
      a_q       <= ZERO;
      b_q       <= ZERO;
      rem_q     <= ZERO;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      tag_q     <= '0;
      result_q  <= ZERO;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_rv_exec_unit.sv
// Directed testbench for rv_exec_unit (XLEN=32, MUL_LAT=2): arithmetic reference model plus
// a per-cycle compare process over out_valid, in_ready, result, tag_out and illegal.
module tb_rv_exec_unit;
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3, OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_OR = 5'd8, OP_AND = 5'd9;
  localparam logic [4:0] OP_MUL = 5'd10, OP_MULH = 5'd11, OP_MULHSU = 5'd12, OP_MULHU = 5'd13;
  localparam logic [4:0] OP_DIV = 5'd14, OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [4:0]  op, tag_in, tag_out;
  logic [31:0] a, b, result;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] lit;
    logic [4:0]  tag;
    logic        ill;
    int          due;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res = 32'd0;

  rv_exec_unit #(.XLEN(32), .TAG_W(5), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .tag_out(tag_out), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference: {illegal, result} straight from the RV32IM definitions.
  function automatic logic [32:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy, p;
    logic [31:0] r;
    logic        ill;
    sx = $signed(x); sy = $signed(y);
    ux = {32'd0, x}; uy = {32'd0, y};
    ill = 1'b0;
    r = 32'd0;
    p = 64'd0;
    case (o)
      OP_ADD:    r = x + y;
      OP_SUB:    r = x - y;
      OP_SLL:    r = x << y[4:0];
      OP_SLT:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      OP_SLTU:   r = (x < y) ? 32'd1 : 32'd0;
      OP_XOR:    r = x ^ y;
      OP_SRL:    r = x >> y[4:0];
      OP_SRA:    r = $signed(x) >>> y[4:0];
      OP_OR:     r = x | y;
      OP_AND:    r = x & y;
      OP_MUL:    begin p = sx * sy; r = p[31:0]; end
      OP_MULH:   begin p = sx * sy; r = p[63:32]; end
      OP_MULHSU: begin p = sx * $signed(uy); r = p[63:32]; end
      OP_MULHU:  begin p = ux * uy; r = p[63:32]; end
      OP_DIV:    if (y == 32'd0) r = 32'hFFFFFFFF;
                 else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
                 else r = $signed(x) / $signed(y);
      OP_DIVU:   r = (y == 32'd0) ? 32'hFFFFFFFF : x / y;
      OP_REM:    if (y == 32'd0) r = x;
                 else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
                 else r = $signed(x) % $signed(y);
      OP_REMU:   r = (y == 32'd0) ? x : x % y;
      default:   begin ill = 1'b1; r = 32'd0; end
    endcase
    return {ill, r};
  endfunction

  function automatic int lat_of(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o >= 5'd18 || o <= OP_AND) return 1;
    if (o <= OP_MULHU) return 2;
    if (y == 32'd0) return 1;
    if ((o == OP_DIV || o == OP_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Offer an op until accepted (bounded); the expected entry is queued in the accept cycle.
  task automatic issue(input string nm, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, input logic [31:0] lit);
    int n = 0;
    logic [32:0] m;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; tag_in = t;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check({nm, "_accept"}, {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      m = model(o, x, y);
      check({nm, "_model"}, m[31:0], lit);
      e.exp = m[31:0]; e.lit = lit; e.tag = t; e.ill = m[32];
      e.acc = cyc; e.due = cyc + lat_of(o, x, y);
      q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom_range(0, 31));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk); #3; n++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  // Per-cycle compare against the queued expectations.
  initial begin
    logic exp_v, exp_r;
    forever begin
      @(negedge clk); #2;
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      exp_r = !flush && !rst && ((q.size() == 0) || (q[0].acc == cyc) || (exp_v && out_ready));
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_r});
      if (exp_v && out_valid) begin
        check("result", result, q[0].exp);
        check("result_lit", result, q[0].lit);
        check("tag_out", {27'd0, tag_out}, {27'd0, q[0].tag});
        check("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
        last_res = q[0].exp;
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 5'd0; a = 32'd0; b = 32'd0; tag_in = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_tag", {27'd0, tag_out}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);

    // ALU back-to-back at one per cycle
    issue("add", OP_ADD, 32'd5, 32'd7, 5'd1, 32'd12);
    issue("sub", OP_SUB, 32'd3, 32'd5, 5'd2, 32'hFFFFFFFE);
    issue("sra", OP_SRA, 32'h80000000, 32'd4, 5'd3, 32'hF8000000);
    issue("sltu", OP_SLTU, 32'd1, 32'hFFFFFFFF, 5'd4, 32'd1);
    issue("slt", OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd5, 32'd1);
    issue("sll", OP_SLL, 32'd1, 32'd31, 5'd6, 32'h80000000);
    issue("sll_wrap", OP_SLL, 32'd3, 32'h21, 5'd7, 32'd6);
    issue("srl", OP_SRL, 32'h80000000, 32'd4, 5'd8, 32'h08000000);
    issue("xor", OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 5'd9, 32'h0FF00FF0);
    issue("or", OP_OR, 32'h0F, 32'hF0, 5'd10, 32'hFF);
    issue("and", OP_AND, 32'hF0F0, 32'hFF00, 5'd11, 32'hF000);
    idle(); drain();

    // Multiplies
    issue("mulh", OP_MULH, 32'hFFFFFFFF, 32'd2, 5'd12, 32'hFFFFFFFF);
    issue("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'd2, 5'd13, 32'h00000001);
    issue("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 5'd14, 32'hFFFFFFFF);
    issue("mul0", OP_MUL, 32'h10000, 32'h10000, 5'd15, 32'd0);
    issue("mul", OP_MUL, 32'hFFFFFFFF, 32'd2, 5'd16, 32'hFFFFFFFE);
    issue("add_after_mul", OP_ADD, 32'd1, 32'd1, 5'd17, 32'd2);
    idle(); drain();

    // Divides and special cases
    issue("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd18, 32'hFFFFFFFD);
    issue("rem", OP_REM, 32'hFFFFFFF9, 32'd2, 5'd19, 32'hFFFFFFFF);
    issue("divu", OP_DIVU, 32'd100, 32'd7, 5'd20, 32'd14);
    issue("remu", OP_REMU, 32'd100, 32'd7, 5'd21, 32'd2);
    issue("div_nb", OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd22, 32'hFFFFFFFD);
    issue("rem_nb", OP_REM, 32'd7, 32'hFFFFFFFE, 5'd23, 32'd1);
    issue("div_min2", OP_DIV, 32'h80000000, 32'd2, 5'd24, 32'hC0000000);
    issue("rem_min3", OP_REM, 32'h80000000, 32'd3, 5'd25, 32'hFFFFFFFE);
    issue("div0", OP_DIV, 32'd9, 32'd0, 5'd26, 32'hFFFFFFFF);
    issue("remu0", OP_REMU, 32'd9, 32'd0, 5'd27, 32'd9);
    issue("divu0", OP_DIVU, 32'd9, 32'd0, 5'd28, 32'hFFFFFFFF);
    issue("rem0", OP_REM, 32'd9, 32'd0, 5'd29, 32'd9);
    issue("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd30, 32'h80000000);
    issue("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 5'd31, 32'd0);
    idle(); drain();

    // Illegal opcodes
    issue("ill25", 5'd25, 32'd4, 32'd5, 5'd3, 32'd0);
    issue("ill18", 5'd18, 32'd4, 32'd5, 5'd4, 32'd0);
    idle(); drain();

    // Backpressure: result and tag must hold for five cycles
    out_ready = 1'b0;
    issue("bp_add", OP_ADD, 32'd20, 32'd22, 5'd17, 32'd42);
    idle();
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Flush at cycle 10 of a divide, with an op offered in the flush cycle
    issue("fl_div", OP_DIVU, 32'd100, 32'd7, 5'd4, 32'd14);
    idle();
    repeat (8) @(negedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1; tag_in = 5'd6;
    @(posedge clk); #1; q.delete();
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; #3;
    check("flush_result_kept", result, last_res);
    check("flush_last_is_bp", last_res, 32'd42);
    issue("fl_add", OP_ADD, 32'd1, 32'd2, 5'd2, 32'd3);
    idle(); drain();

    // Reset in the middle of a multiply
    issue("rst_mul", OP_MUL, 32'd3, 32'd4, 5'd9, 32'd12);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; q.delete();
    @(negedge clk);
    rst = 1'b0; #3;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_tag", {27'd0, tag_out}, 32'd0);
    check("midrst_illegal", {31'd0, illegal}, 32'd0);
    issue("post_rst_add", OP_ADD, 32'd5, 32'd7, 5'd1, 32'd12);
    idle(); drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_exec_unit.md
Name: rv_exec_unit

Overview:
- Parametrised, multi-cycle integer execute unit; next generation of the single-cycle RV32I ALU.
- Adds RV32M multiply/divide, XLEN generalisation, a destination tag, valid/ready handshake on both sides, and a flush.
- Sits between decode/register read and writeback. Holds one operation in flight.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- TAG_W, 5, width of the passthrough tag (destination register index).
- MUL_LAT, 2, cycles from accept to out_valid for MUL* ops; must be >= 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  aborts the in-flight or pending operation.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18-31 illegal.
- a  in  XLEN  operand 1.
- b  in  XLEN  operand 2 (register value or already-extended immediate).
- tag_in  in  TAG_W  tag captured on accept.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  result value.
- tag_out  out  TAG_W  tag of the result.
- illegal  out  1  result is from an illegal op.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, tag_out=0, illegal=0, counters=0. in_ready=1 in the first cycle after reset.
- States:
  - IDLE: wait for an operation.
  - MUL: count MUL_LAT-1 cycles.
  - DIV: iterate XLEN cycles.
  - DONE: out_valid=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational; forced to 0 while flush or rst.
- Accept = in_valid & in_ready. On accept, capture op, a, b and tag_in.
- ALU ops (0-9), illegal ops, and divide special cases: go to DONE next cycle, so out_valid rises 1 cycle after accept.
- Illegal op: result=0, illegal=1.
- Shifts use b[log2(XLEN)-1:0]. SRA is arithmetic. SLT is signed; SLTU is unsigned.
- MUL path:
  - Full 2*XLEN product of the sign-adjusted operands.
  - MULHSU: a signed, b unsigned.
  - MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - out_valid rises exactly MUL_LAT cycles after accept. With MUL_LAT=1, go directly to DONE.
- DIV path:
  - Restoring divider on magnitudes, one quotient bit per cycle, XLEN cycles in DIV.
  - Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - out_valid rises XLEN+1 cycles after accept.
- Divide special cases, decided at accept and completed in 1 cycle:
  - b==0: DIV/DIVU result = all ones; REM/REMU result = a.
  - Signed overflow (a = most negative, b = -1): DIV result = a; REM result = 0.
- DONE:
  - result, tag_out and illegal are held stable while out_valid & !out_ready.
  - On out_ready with no new accept: IDLE, out_valid=0 next cycle.
  - On out_ready with a simultaneous accept: the new op starts. For an ALU op, out_valid stays 1 with the new result next cycle (back-to-back throughput of 1 per cycle). For MUL/DIV, out_valid=0 next cycle.
- flush: highest priority after rst.
  - Next cycle: state=IDLE, out_valid=0, counters cleared, result retained.
  - No accept occurs in a flush cycle.
  - A held-but-unconsumed result is discarded.
- rst mid-operation: same as reset values next cycle; partial divider/multiplier state is discarded.
- Inputs a, b, op may change after accept without affecting the in-flight op.

Test Plan:
- ALU back-to-back, out_ready=1:
  - ADD a=5, b=7 -> 12 one cycle after accept.
  - Next cycle, SUB a=3, b=5 -> 0xFFFFFFFE.
  - SRA a=0x80000000, b=4 -> 0xF8000000.
  - SLTU a=1, b=0xFFFFFFFF -> 1.
  - Throughput is 1 per cycle.
- MUL, MUL_LAT=2:
  - MULH a=0xFFFFFFFF (-1), b=2 -> 0xFFFFFFFF.
  - MULHU on the same operands -> 0x00000001.
  - MUL a=0x10000, b=0x10000 -> 0.
  - out_valid exactly 2 cycles after accept; in_ready=0 in between.
- DIV:
  - DIV a=-7, b=2 -> -3 (0xFFFFFFFD); REM on the same operands -> -1.
  - DIVU a=100, b=7 -> 14.
  - out_valid exactly 33 cycles after accept.
- Divide special cases:
  - DIV a=9, b=0 -> 0xFFFFFFFF; REMU a=9, b=0 -> 9.
  - DIV a=0x80000000, b=-1 -> 0x80000000; REM on the same operands -> 0.
  - Each completes 1 cycle after accept.
- Backpressure and tag:
  - out_ready=0 for 5 cycles after an ADD with tag 17 -> result and tag_out=17 stable and in_ready=0 throughout.
  - Illegal op 25 -> result=0, illegal=1.
- Flush and reset:
  - flush at cycle 10 of a DIV -> out_valid stays 0 and in_ready=1 next cycle; a following ADD completes normally.
  - rst asserted mid-MUL -> all outputs at reset values next cycle.
